// File: rtl/core_lsu_rsp_wb.sv
// core_lsu_rsp_wb: load/store response tracker and GPR writeback unit.
// Each accepted dmem request is tagged in an in-order FIFO. When its response
// returns, the data is aligned and extended, then offered on a valid/ready
// writeback port. A bus error on a response raises a one-cycle access-fault
// trap. After a flush, responses to requests issued before the flush are
// dropped.
//
// Ports
//   g_clk, g_reset          clock, synchronous active-high reset
//   req_valid/req_ready     request issue; req_op {sext,double,word,half,byte,store,load}
//   req_rd, req_addr        destination GPR and request address
//   rsp_valid/rsp_ready     dmem response; rsp_err bus error, rsp_rdata raw data
//   flush                   discard all outstanding requests
//   wb_valid/wb_ready       GPR write; wb_rd address, wb_wdata aligned data
//   trap_valid/cause/mtval  access-fault pulse (5 load, 7 store) and faulting address
//   outstanding             live tag count
//   err_unexp               sticky: response arrived with no live or dropped tag
//
// Optional build macro: CORE_LSU_RSP_BYPASS_EN. When defined, a good load
// response is forwarded combinationally to the writeback port when the hold
// register is empty and wb_ready is high.
module core_lsu_rsp_wb #(
    parameter int unsigned XLEN  = 64,
    parameter int unsigned DEPTH = 2,
    parameter int unsigned RW    = 5
) (
    input  logic                     g_clk,
    input  logic                     g_reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [6:0]               req_op,
    input  logic [RW-1:0]            req_rd,
    input  logic [XLEN-1:0]          req_addr,
    input  logic                     rsp_valid,
    output logic                     rsp_ready,
    input  logic                     rsp_err,
    input  logic [XLEN-1:0]          rsp_rdata,
    input  logic                     flush,
    output logic                     wb_valid,
    input  logic                     wb_ready,
    output logic [RW-1:0]            wb_rd,
    output logic [XLEN-1:0]          wb_wdata,
    output logic                     trap_valid,
    output logic [5:0]               trap_cause,
    output logic [XLEN-1:0]          trap_mtval,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_unexp
);

    localparam int unsigned OFFW = $clog2(XLEN/8);
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned IW   = $clog2(XLEN);

    typedef struct packed {
        logic [6:0]      op;
        logic [RW-1:0]   rd;
        logic [OFFW-1:0] off;
        logic [XLEN-1:0] addr;
    } tag_t;

    tag_t            tag_q [DEPTH];
    tag_t            head;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   cnt, drop;
    logic            hold_v;
    logic [RW-1:0]   hold_rd;
    logic [XLEN-1:0] hold_data;

    logic            push, rsp_fire, pop, drop_rsp, good_load, hold_load, unexp;
    logic [XLEN-1:0] shifted, aligned;
    logic [IW-1:0]   sidx;

    // Handshake qualifiers
    assign req_ready = !g_reset && (cnt < CW'(DEPTH)) && (drop == '0) && !flush;
    assign rsp_ready = !hold_v || wb_ready;
    assign push      = req_valid && req_ready;
    assign rsp_fire  = rsp_valid && rsp_ready;
    assign pop       = rsp_fire && (drop == '0) && (cnt != '0);
    assign drop_rsp  = rsp_fire && (drop != '0);
    assign unexp     = rsp_valid && (cnt == '0) && (drop == '0);
    assign head      = tag_q[rd_ptr];
    assign good_load = pop && head.op[0] && !rsp_err && (head.rd != '0);
    assign outstanding = cnt;

    // Align by byte offset, then mask/extend to the access size
    always_comb begin
        shifted = rsp_rdata >> {head.off, 3'b000};
        sidx    = IW'(XLEN - 1);
        if (head.op[2])      sidx = IW'(7);
        else if (head.op[3]) sidx = IW'(15);
        else if (head.op[4]) sidx = IW'(31);
        if (head.op[5]) begin
            aligned = rsp_rdata;
        end else begin
            aligned = shifted;
            for (int unsigned i = 0; i < XLEN; i++) begin
                if (i > 32'(sidx)) aligned[i] = head.op[6] & shifted[sidx];
            end
        end
    end

`ifdef CORE_LSU_RSP_BYPASS_EN
    logic bypass_c;
    assign bypass_c  = good_load && !hold_v && wb_ready;
    assign hold_load = good_load && !bypass_c;
    assign wb_valid  = hold_v || bypass_c;
    assign wb_rd     = hold_v ? hold_rd   : head.rd;
    assign wb_wdata  = hold_v ? hold_data : aligned;
`else
    assign hold_load = good_load;
    assign wb_valid  = hold_v;
    assign wb_rd     = hold_rd;
    assign wb_wdata  = hold_data;
`endif

    // Tag storage; only written on an accepted request
    always_ff @(posedge g_clk) begin
        if (push) tag_q[wr_ptr] <= '{op: req_op, rd: req_rd,
                                     off: req_addr[OFFW-1:0], addr: req_addr};
    end

    // Pointers, counters, writeback hold register, trap and error flags
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            drop       <= '0;
            hold_v     <= 1'b0;
            hold_rd    <= '0;
            hold_data  <= '0;
            trap_valid <= 1'b0;
            trap_cause <= '0;
            trap_mtval <= '0;
            err_unexp  <= 1'b0;
        end else begin
            if (flush) begin
                // Only one of drop/cnt can be nonzero, so the sum is the live total
                wr_ptr <= '0;
                rd_ptr <= '0;
                cnt    <= '0;
                drop   <= drop + cnt - CW'(rsp_fire && ((cnt != '0) || (drop != '0)));
            end else begin
                if (push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
                if (pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
                cnt <= cnt + CW'(push) - CW'(pop);
                if (drop_rsp) drop <= drop - CW'(1);
            end

            // Refill in the same cycle as a drain keeps hold_v high
            if (hold_load) begin
                hold_v    <= 1'b1;
                hold_rd   <= head.rd;
                hold_data <= aligned;
            end else if (wb_ready) begin
                hold_v    <= 1'b0;
            end

            trap_valid <= pop && rsp_err;
            if (pop && rsp_err) begin
                trap_cause <= head.op[1] ? 6'd7 : 6'd5;
                trap_mtval <= head.addr;
            end

            if (unexp) err_unexp <= 1'b1;
        end
    end

endmodule
